// File: rtl/alu_pkg.sv
// Shared constants for the registered MIPS ALU: data width, group codes and function codes.
// Optional feature macro used by the top level: ALU_LUI_EN.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FUN_W   = 6;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_CMP   = 2'b11;

    localparam logic [FUN_W-1:0] FUN_ADD  = 6'b000000;
    localparam logic [FUN_W-1:0] FUN_SUB  = 6'b000001;

    localparam logic [FUN_W-1:0] FUN_AND  = 6'b011000;
    localparam logic [FUN_W-1:0] FUN_OR   = 6'b011110;
    localparam logic [FUN_W-1:0] FUN_XOR  = 6'b010110;
    localparam logic [FUN_W-1:0] FUN_NOR  = 6'b010001;
    localparam logic [FUN_W-1:0] FUN_PASA = 6'b011010;
    localparam logic [FUN_W-1:0] FUN_LUI  = 6'b011011;

    localparam logic [FUN_W-1:0] FUN_SLL  = 6'b100000;
    localparam logic [FUN_W-1:0] FUN_SRL  = 6'b100001;
    localparam logic [FUN_W-1:0] FUN_SRA  = 6'b100011;

    localparam logic [FUN_W-1:0] FUN_EQ   = 6'b110011;
    localparam logic [FUN_W-1:0] FUN_NEQ  = 6'b110001;
    localparam logic [FUN_W-1:0] FUN_LT   = 6'b110101;
    localparam logic [FUN_W-1:0] FUN_LEZ  = 6'b111101;
    localparam logic [FUN_W-1:0] FUN_LTZ  = 6'b111011;
    localparam logic [FUN_W-1:0] FUN_GEZ  = 6'b111001;
    localparam logic [FUN_W-1:0] FUN_GTZ  = 6'b111111;

    // Zero-extend a single condition bit to a full result word.
    function automatic logic [DATA_W-1:0] cond_word(input logic cond);
        return {{(DATA_W-1){1'b0}}, cond};
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared combinational adder/subtractor with Z/V/N flag generation,
// supporting both signed and unsigned interpretation of the operands.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_sub,
    input  logic              i_sign,
    output logic [DATA_W-1:0] o_sum_c,
    output logic              o_z_c,
    output logic              o_v_c,
    output logic              o_n_c
);

    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W:0]   w_full;
    logic              w_carry;
    logic              w_ovf;

    // Subtraction as A + ~B + 1; carry-out of 0 then means a borrow.
    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + (DATA_W+1)'(i_sub);
    assign w_carry = w_full[DATA_W];
    assign o_sum_c = w_full[DATA_W-1:0];

    assign w_ovf = (i_a[DATA_W-1] == w_b_eff[DATA_W-1]) &&
                   (o_sum_c[DATA_W-1] != i_a[DATA_W-1]);

    assign o_z_c = (o_sum_c == '0);

    always_comb begin
        o_v_c = 1'b0;
        o_n_c = 1'b0;
        if (i_sign) begin
            o_v_c = w_ovf;
            o_n_c = o_sum_c[DATA_W-1] ^ w_ovf;
        end else if (i_sub) begin
            o_v_c = ~w_carry;
            o_n_c = ~w_carry;
        end else begin
            o_v_c = w_carry;
        end
    end

endmodule

// File: rtl/alu.sv
// Registered 32-bit MIPS ALU: arithmetic, logic, shift and compare groups, one clock of latency.
// Optional feature: define ALU_LUI_EN to enable the LUI function code.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] iA,
    input  logic [DATA_W-1:0] iB,
    input  logic [FUN_W-1:0]  iALUFun,
    input  logic              iSign,
    output logic [DATA_W-1:0] oS,
    output logic              oZ,
    output logic              oV,
    output logic              oN
);

    logic [1:0]         w_grp;
    logic               w_sub;
    logic               w_sign;
    logic [DATA_W-1:0]  w_sum;
    logic               w_z;
    logic               w_v;
    logic               w_n;

    logic [SHAMT_W-1:0] w_shamt;
    logic [DATA_W-1:0]  w_sra;
    logic               w_a_neg;
    logic               w_a_zero;

    logic [DATA_W-1:0]  w_arith;
    logic [DATA_W-1:0]  w_logic;
    logic [DATA_W-1:0]  w_shift;
    logic [DATA_W-1:0]  w_cmp;
    logic [DATA_W-1:0]  w_s;
    logic               w_flags_en;

    logic [DATA_W-1:0]  r_s;
    logic               r_z;
    logic               r_v;
    logic               r_n;

    assign w_grp = iALUFun[FUN_W-1:FUN_W-2];

    // Only ADD runs the adder in add mode; SUB and the A/B compares subtract.
    assign w_sub  = (iALUFun != FUN_ADD);
    assign w_sign = iSign;

    alu_addsub u_addsub (
        .i_a     (iA),
        .i_b     (iB),
        .i_sub   (w_sub),
        .i_sign  (w_sign),
        .o_sum_c (w_sum),
        .o_z_c   (w_z),
        .o_v_c   (w_v),
        .o_n_c   (w_n)
    );

    assign w_shamt  = iA[SHAMT_W-1:0];
    assign w_sra    = DATA_W'($signed(iB) >>> w_shamt);
    assign w_a_neg  = iA[DATA_W-1];
    assign w_a_zero = (iA == '0);

    always_comb begin
        w_arith    = '0;
        w_flags_en = 1'b0;
        case (iALUFun)
            FUN_ADD, FUN_SUB: begin
                w_arith    = w_sum;
                w_flags_en = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_logic = '0;
        case (iALUFun)
            FUN_AND:  w_logic = iA & iB;
            FUN_OR:   w_logic = iA | iB;
            FUN_XOR:  w_logic = iA ^ iB;
            FUN_NOR:  w_logic = ~(iA | iB);
            FUN_PASA: w_logic = iA;
`ifdef ALU_LUI_EN
            FUN_LUI:  w_logic = {iB[15:0], 16'b0};
`endif
            default:  w_logic = '0;
        endcase
    end

    always_comb begin
        w_shift = '0;
        case (iALUFun)
            FUN_SLL: w_shift = iB << w_shamt;
            FUN_SRL: w_shift = iB >> w_shamt;
            FUN_SRA: w_shift = w_sra;
            default: w_shift = '0;
        endcase
    end

    // Zero compares look only at A, always as a signed value.
    always_comb begin
        w_cmp = '0;
        case (iALUFun)
            FUN_EQ:  w_cmp = cond_word(w_z);
            FUN_NEQ: w_cmp = cond_word(~w_z);
            FUN_LT:  w_cmp = cond_word(w_n);
            FUN_LEZ: w_cmp = cond_word(w_a_neg | w_a_zero);
            FUN_LTZ: w_cmp = cond_word(w_a_neg);
            FUN_GEZ: w_cmp = cond_word(~w_a_neg);
            FUN_GTZ: w_cmp = cond_word(~w_a_neg & ~w_a_zero);
            default: w_cmp = '0;
        endcase
    end

    always_comb begin
        w_s = '0;
        case (w_grp)
            GRP_ARITH: w_s = w_arith;
            GRP_LOGIC: w_s = w_logic;
            GRP_SHIFT: w_s = w_shift;
            GRP_CMP:   w_s = w_cmp;
            default:   w_s = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= '0;
            r_z <= 1'b0;
            r_v <= 1'b0;
            r_n <= 1'b0;
        end else begin
            r_s <= w_s;
            r_z <= w_flags_en & w_z;
            r_v <= w_flags_en & w_v;
            r_n <= w_flags_en & w_n;
        end
    end

    assign oS = r_s;
    assign oZ = r_z;
    assign oV = r_v;
    assign oN = r_n;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for the registered ALU with hand-computed expected values.
// Honors ALU_LUI_EN to pick the expected LUI result.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] iA;
    logic [31:0] iB;
    logic [5:0]  iALUFun;
    logic        iSign;
    logic [31:0] oS;
    logic        oZ;
    logic        oV;
    logic        oN;

    int checks;
    int failures;

    alu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iA      (iA),
        .iB      (iB),
        .iALUFun (iALUFun),
        .iSign   (iSign),
        .oS      (oS),
        .oZ      (oZ),
        .oV      (oV),
        .oN      (oN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, sample 1ns after the next rising edge.
    task automatic op(input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] fun, input logic sgn);
        @(negedge clk);
        iA = a;
        iB = b;
        iALUFun = fun;
        iSign = sgn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] s,
                           input logic z, input logic v, input logic n);
        chk({tag, ".S"}, oS, s);
        chk({tag, ".ZVN"}, {29'b0, oZ, oV, oN}, {29'b0, z, v, n});
    endtask

    logic [31:0] lui_exp;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        iA       = 32'h0;
        iB       = 32'h0;
        iALUFun  = 6'b0;
        iSign    = 1'b0;
`ifdef ALU_LUI_EN
        lui_exp = 32'h00D9_0000;
`else
        lui_exp = 32'h0;
`endif

        // Reset state, with nonzero inputs present during reset edges.
        iA = 32'd7; iB = 32'd8;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        op(32'd7, 32'd8, 6'b000000, 1'b0);
        chk_all("add_u", 32'd15, 1'b0, 1'b0, 1'b0);
        op(32'd7, 32'd8, 6'b000001, 1'b1);
        chk_all("sub_s", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        op(32'd7, 32'd8, 6'b000001, 1'b0);
        chk_all("sub_u_borrow", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
        op(32'h7FFF_FFFF, 32'd1, 6'b000000, 1'b1);
        chk_all("add_s_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        op(32'hFFFF_FFFF, 32'd1, 6'b000000, 1'b0);
        chk_all("add_u_carry", 32'h0, 1'b1, 1'b1, 1'b0);
        op(32'h8000_0000, 32'd1, 6'b000001, 1'b1);
        chk_all("sub_s_ovf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        op(32'd9, 32'd9, 6'b000001, 1'b1);
        chk_all("sub_zero", 32'h0, 1'b1, 1'b0, 1'b0);

        op(32'h8000_00D9, 32'h0000_00AA, 6'b011000, 1'b1);
        chk_all("and", 32'h0000_0088, 1'b0, 1'b0, 1'b0);
        op(32'h8000_00D9, 32'h0000_00AA, 6'b011110, 1'b1);
        chk_all("or", 32'h8000_00FB, 1'b0, 1'b0, 1'b0);
        op(32'h8000_00D9, 32'h0000_00AA, 6'b010110, 1'b1);
        chk("xor", oS, 32'h8000_0073);
        op(32'h8000_00D9, 32'h0000_00AA, 6'b010001, 1'b1);
        chk("nor", oS, 32'h7FFF_FF04);
        op(32'h8000_00D9, 32'h0000_00AA, 6'b011010, 1'b1);
        chk("pass_a", oS, 32'h8000_00D9);
        op(32'h0, 32'h8000_00D9, 6'b011011, 1'b0);
        chk("lui", oS, lui_exp);

        op(32'd4, 32'h8000_00D9, 6'b100000, 1'b0);
        chk_all("sll", 32'h0000_0D90, 1'b0, 1'b0, 1'b0);
        op(32'd4, 32'h8000_00D9, 6'b100001, 1'b0);
        chk("srl", oS, 32'h0800_000D);
        op(32'd4, 32'h8000_00D9, 6'b100011, 1'b0);
        chk("sra", oS, 32'hF800_000D);
        op(32'hFFFF_FFE4, 32'h8000_00D9, 6'b100011, 1'b0);
        chk("sra_amt_low5", oS, 32'hF800_000D);

        op(32'd7, 32'd7, 6'b110011, 1'b1);
        chk_all("eq", 32'd1, 1'b0, 1'b0, 1'b0);
        op(32'd7, 32'd6, 6'b110011, 1'b1);
        chk("eq_false", oS, 32'd0);
        op(32'd7, 32'd6, 6'b110001, 1'b1);
        chk("neq", oS, 32'd1);
        op(32'd5, 32'd6, 6'b110101, 1'b1);
        chk("lt", oS, 32'd1);
        op(32'hFFFF_FFFF, 32'd1, 6'b110101, 1'b1);
        chk("lt_signed_neg", oS, 32'd1);
        op(32'hFFFF_FFFF, 32'd1, 6'b110101, 1'b0);
        chk("lt_unsigned_big", oS, 32'd0);
        op(32'hFFFF_FFFE, 32'd0, 6'b111101, 1'b0);
        chk("lez_neg", oS, 32'd1);
        op(32'hFFFF_FFFE, 32'd0, 6'b111011, 1'b0);
        chk("ltz_neg", oS, 32'd1);
        op(32'd0, 32'd0, 6'b111001, 1'b0);
        chk("gez_zero", oS, 32'd1);
        op(32'd0, 32'd0, 6'b111111, 1'b0);
        chk("gtz_zero", oS, 32'd0);
        op(32'd3, 32'd0, 6'b111111, 1'b0);
        chk("gtz_pos", oS, 32'd1);

        op(32'd7, 32'd8, 6'b000010, 1'b1);
        chk_all("undef_code", 32'h0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges while a nonzero result is held.
        op(32'hFFFF_FFFF, 32'd0, 6'b000000, 1'b1);
        chk_all("pre_reset", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        op(32'd1, 32'd2, 6'b000000, 1'b0);
        chk("post_reset_add", oS, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
